// File: rtl/mandel_pkg.sv
// Shared widths for the fixed-point Mandelbrot datapath.
package mandel_pkg;
    localparam int DATA_W  = 31;
    localparam int SHIFT_W = 5;

    // Requester ID width; a single requester still needs one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/clz_normalize_arbiter_rr_grant.sv
// Round-robin grant: first valid requester at or above ptr, wrapping.
// Purely combinational; the pointer register lives in the parent.
module rr_grant
    import mandel_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id,
    output logic            any
);
    int idx;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        idx      = 0;
        for (int off = 0; off < NREQ; off++) begin
            idx = (int'(ptr) + off) % NREQ;
            if (!any && valid[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = IDW'(idx);
            end
        end
    end
endmodule

// File: rtl/count_leading_zeroes.sv
// Combinational leading-zero encoder for a DATA_W operand.
// The count is meaningless for a zero input; callers mask that case.
module count_leading_zeroes
    import mandel_pkg::*;
(
    input  logic [DATA_W-1:0]  data,
    output logic [SHIFT_W-1:0] count
);
    always_comb begin
        count = '0;
        // Ascending scan: the highest set bit is the last to assign.
        for (int i = 0; i < DATA_W; i++) begin
            if (data[i]) begin
                count = SHIFT_W'(DATA_W - 1 - i);
            end
        end
    end
endmodule

// File: rtl/clz_normalize_arbiter.sv
// Shared normalizer: round-robin arbitration into a two-stage pipeline that
// left-justifies each 31-bit operand and reports shift, zero flag and source.
module clz_normalize_arbiter
    import mandel_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = id_width(NREQ)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [DATA_W-1:0]      res_data,
    output logic [SHIFT_W-1:0]     res_shift,
    output logic                   res_zero,
    output logic [IDW-1:0]         res_id
);
    logic [DATA_W-1:0]  operand [NREQ];
    logic [NREQ-1:0]    grant;
    logic [IDW-1:0]     grant_id;
    logic               grant_any;
    logic [IDW-1:0]     rr_ptr;
    logic [IDW-1:0]     rr_ptr_next;
    logic               s1_valid;
    logic [DATA_W-1:0]  s1_data;
    logic [IDW-1:0]     s1_id;
    logic               s1_en;
    logic               s2_en;
    logic               accept;
    logic               s1_zero;
    logic [SHIFT_W-1:0] clz_count;
    logic [DATA_W-1:0]  shifted_next;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign operand[gi] = req_data[DATA_W*gi +: DATA_W];
        end
    endgenerate

    rr_grant #(.NREQ(NREQ), .IDW(IDW)) u_rr_grant (
        .valid    (req_valid),
        .ptr      (rr_ptr),
        .grant    (grant),
        .grant_id (grant_id),
        .any      (grant_any)
    );

    assign s2_en       = !res_valid || res_ready;
    assign s1_en       = !s1_valid || s2_en;
    assign req_ready   = grant & {NREQ{s1_en && reset_n}};
    assign accept      = grant_any && s1_en && reset_n;
    assign rr_ptr_next = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_ptr   <= '0;
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_id    <= '0;
        end else begin
            if (accept) begin
                rr_ptr <= rr_ptr_next;
            end
            if (s1_en) begin
                s1_valid <= accept;
                if (accept) begin
                    s1_data <= operand[grant_id];
                    s1_id   <= grant_id;
                end
            end
        end
    end

    count_leading_zeroes u_clz (
        .data  (s1_data),
        .count (clz_count)
    );

    assign s1_zero      = (s1_data == '0);
    assign shifted_next = s1_data << clz_count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_shift <= '0;
            res_zero  <= 1'b0;
            res_id    <= '0;
        end else if (s2_en) begin
            res_valid <= s1_valid;
            if (s1_valid) begin
                // Zero operand: encoder output is don't-care, so force all fields.
                res_data  <= s1_zero ? '0 : shifted_next;
                res_shift <= s1_zero ? '0 : clz_count;
                res_zero  <= s1_zero;
                res_id    <= s1_id;
            end
        end
    end
endmodule
